isa_bus_cycle_engine: RTL and testbench

- Parametrised successor to the fixed bus-interface/state-machine pair on the riser.
- Accepts single I/O or DMA transfer requests from the HPS side and executes one ISA-style cycle per request: address setup, IOR#/IOW# strobe, IOCHRDY wait-state extension with timeout, then hold.
- Bus width, cycle timing and DMA channel count are parameters. DACK and AEN are driven for DMA cycles.
- Sits between the HPS register block and the card-edge pins, clocked from the 8 MHz bus clock.

---
 rtl/isa_bus_cycle_engine.sv | 213 +++++++++++++++++++++
 tb/tb_isa_bus_cycle_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_bus_cycle_engine.sv
// ISA bus cycle engine: runs one I/O or DMA bus cycle per request with
// address setup, IOR#/IOW# strobe, IOCHRDY wait states with timeout, then hold.
module isa_bus_cycle_engine #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int DMA_CHANNELS  = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int READY_TIMEOUT = 255,
  localparam int CHAN_W = (DMA_CHANNELS > 1) ? $clog2(DMA_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_dma,
  input  logic [CHAN_W-1:0]       req_chan,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   addr_bus,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_oe,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    ior_n,
  output logic                    iow_n,
  output logic                    aen,
  output logic [DMA_CHANNELS-1:0] dack_n,
  input  logic                    iochrdy,
  input  logic [DMA_CHANNELS-1:0] drq,
  output logic [DMA_CHANNELS-1:0] drq_sync
);

  localparam int MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT_RDY,
    S_HOLD,
    S_RESP
  } state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    accept, strobe_start, capture, timed_out, rel_pins;
  logic                    write_q, byte_q;
  logic [1:0]              rdy_meta;
  logic                    rdy_sync;
  logic [DMA_CHANNELS-1:0] drq_meta;
  logic [DMA_CHANNELS-1:0] dack_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_meta <= 2'b11;
      drq_meta <= '0;
      drq_sync <= '0;
    end else begin
      rdy_meta <= {rdy_meta[0], iochrdy};
      drq_meta <= drq;
      drq_sync <= drq_meta;
    end
  end

  assign rdy_sync  = rdy_meta[1];
  assign req_ready = (state == S_IDLE);

  always_comb begin
    dack_sel = '1;
    for (int i = 0; i < DMA_CHANNELS; i++) begin
      if (req_dma && (32'(req_chan) == i)) dack_sel[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // One counter serves every state: it counts down through setup/strobe/hold
  // and counts up while waiting on IOCHRDY.
  always_comb begin
    next_state   = state;
    cnt_next     = cnt;
    accept       = 1'b0;
    strobe_start = 1'b0;
    capture      = 1'b0;
    timed_out    = 1'b0;
    rel_pins     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          next_state = S_SETUP;
          cnt_next   = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          strobe_start = 1'b1;
          next_state   = S_STROBE;
          cnt_next     = CNT_W'(STROBE_CYCLES - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (rdy_sync) begin
          capture    = 1'b1;
          next_state = S_HOLD;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          next_state = S_WAIT_RDY;
          cnt_next   = '0;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_sync) begin
          capture    = 1'b1;
          next_state = S_HOLD;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          next_state = S_HOLD;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          rel_pins   = 1'b1;
          next_state = S_RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Pin and response registers; reset releases every strobe and DACK at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      addr_bus    <= '0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      ior_n       <= 1'b1;
      iow_n       <= 1'b1;
      aen         <= 1'b0;
      dack_n      <= '1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= (state == S_RESP);
      if (accept) begin
        write_q     <= req_write;
        byte_q      <= req_byte | (DATA_WIDTH == 8);
        addr_bus    <= req_dma ? '0 : req_addr;
        data_oe     <= req_write;
        aen         <= req_dma;
        dack_n      <= dack_sel;
        rsp_rdata   <= '0;
        rsp_timeout <= 1'b0;
        if (req_write) begin
          data_out <= (req_byte || (DATA_WIDTH == 8)) ? (req_wdata & BYTE_MASK) : req_wdata;
        end
      end
      if (strobe_start) begin
        ior_n <= write_q;
        iow_n <= !write_q;
      end
      if (capture || timed_out) begin
        ior_n <= 1'b1;
        iow_n <= 1'b1;
      end
      if (capture && !write_q) begin
        rsp_rdata <= byte_q ? (data_in & BYTE_MASK) : data_in;
      end
      if (timed_out) begin
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '1;
      end
      if (rel_pins) begin
        data_oe <= 1'b0;
        aen     <= 1'b0;
        dack_n  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_isa_bus_cycle_engine.sv
// Self-checking bench for isa_bus_cycle_engine: directed scenarios plus random
// transfers compared against a transaction-level timing/data model.
`timescale 1ns/1ps
module tb_isa_bus_cycle_engine;

  localparam int SETUP  = 1;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int TMO    = 255;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write, req_dma, req_byte;
  logic [1:0]  req_chan;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_rdata, addr_bus, data_out, data_in;
  logic        data_oe, ior_n, iow_n, aen, iochrdy;
  logic [3:0]  dack_n, drq, drq_sync;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int strobe_low; int first_low; int wrong_low; int latency; int pulse;
    int aen_cnt; int dack_cnt; int oe_cnt;
    logic [15:0] rdata; logic timeout; logic [15:0] addr; logic [15:0] dout; logic [3:0] dack;
  } obs_t;

  typedef struct {
    int strobe_low; int latency; int window;
    logic [15:0] rdata; logic timeout; logic [15:0] addr; logic [15:0] dout; logic [3:0] dack;
  } exp_t;

  isa_bus_cycle_engine #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DMA_CHANNELS(4), .SETUP_CYCLES(SETUP),
    .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD), .READY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_dma(req_dma), .req_chan(req_chan), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .addr_bus(addr_bus), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .ior_n(ior_n), .iow_n(iow_n), .aen(aen), .dack_n(dack_n),
    .iochrdy(iochrdy), .drq(drq), .drq_sync(drq_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // iochrdy as driven into the edge numbered k (accept edge is 0)
  function automatic logic rdy_drv(input int k, input int lo_start, input int lo_len);
    return !(k >= lo_start && k < lo_start + lo_len);
  endfunction

  function automatic exp_t model(input logic wr, input logic dma, input logic [1:0] ch,
                                 input logic byt, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] din, input int lo_start, input int lo_len);
    exp_t e;
    int w;
    int es;
    es = SETUP + STROBE;
    w = 0;
    e.timeout = 1'b0;
    // the FSM sees ready two edges after it is driven
    if (!rdy_drv(es - 2, lo_start, lo_len)) begin
      w = TMO;
      e.timeout = 1'b1;
      for (int j = 1; j <= TMO; j++) begin
        if (rdy_drv(es + j - 2, lo_start, lo_len)) begin
          w = j;
          e.timeout = 1'b0;
          break;
        end
      end
    end
    e.strobe_low = STROBE + w;
    e.window     = SETUP + STROBE + w + HOLD;
    e.latency    = e.window + 1;
    e.rdata      = e.timeout ? 16'hFFFF : (byt ? {8'h00, din[7:0]} : din);
    e.addr       = dma ? 16'h0000 : addr;
    e.dout       = byt ? {8'h00, wdata[7:0]} : wdata;
    e.dack       = dma ? ~(4'b0001 << ch) : 4'hF;
    return e;
  endfunction

  task automatic sample_pins(input int k, input logic wr, inout obs_t o);
    if (wr ? !iow_n : !ior_n) begin
      o.strobe_low++;
      if (o.first_low < 0) o.first_low = k;
    end
    if (wr ? !ior_n : !iow_n) o.wrong_low++;
    if (aen) o.aen_cnt++;
    if (dack_n != 4'hF) o.dack_cnt++;
    if (data_oe) o.oe_cnt++;
    if (k == SETUP) begin
      o.addr = addr_bus;
      o.dout = data_out;
      o.dack = dack_n;
    end
    if (rsp_valid) begin
      if (o.latency < 0) begin
        o.latency = k;
        o.rdata   = rsp_rdata;
        o.timeout = rsp_timeout;
      end
      o.pulse++;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic dma, input logic [1:0] ch,
                               input logic byt, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] din, input int lo_start, input int lo_len,
                               output obs_t o);
    int k;
    int guard;
    bit done;
    o = '{default: 0};
    o.latency = -1;
    o.first_low = -1;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = wr; req_dma = dma; req_chan = ch; req_byte = byt;
    req_addr = addr; req_wdata = wdata; data_in = din; iochrdy = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_dma = 1'($urandom); req_chan = 2'($urandom);
    req_byte = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    k = 0;
    sample_pins(k, wr, o);
    done = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      iochrdy = rdy_drv(k + 1, lo_start, lo_len);
      @(posedge clk); #1;
      k++;
      if (!rsp_valid && o.latency >= 0) done = 1;
      sample_pins(k, wr, o);
    end
    iochrdy = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drq = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if ({ior_n, iow_n} !== 2'b11) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 11", {ior_n, iow_n}); end
    checks++; if (dack_n !== 4'hF) begin errors++; $display("[TB] FAIL reset_dack: got %h expected f", dack_n); end
    checks++; if ({rsp_valid, rsp_timeout, data_oe, aen} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_lows: got %b expected 0000", {rsp_valid, rsp_timeout, data_oe, aen}); end
    checks++; if ({addr_bus, data_out, rsp_rdata} !== 48'h0) begin errors++; $display("[TB] FAIL reset_zeros: got %h expected 0", {addr_bus, data_out, rsp_rdata}); end
    checks++; if (drq_sync !== 4'h0) begin errors++; $display("[TB] FAIL reset_drq_sync: got %h expected 0", drq_sync); end
    @(negedge clk);
    drq = 4'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_basic;
    obs_t o; exp_t e;
    e = model(1, 0, 0, 0, 16'h0220, 16'hBEEF, 16'h0000, 1, 0);
    applyStimulus(1, 0, 0, 0, 16'h0220, 16'hBEEF, 16'h0000, 1, 0, o);
    checks++; if (o.latency !== 7 || o.latency !== e.latency) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected 7", o.latency); end
    checks++; if (o.strobe_low !== 4) begin errors++; $display("[TB] FAIL wr_iow_low: got %0d expected 4", o.strobe_low); end
    checks++; if (o.first_low !== SETUP) begin errors++; $display("[TB] FAIL wr_iow_start: got %0d expected %0d", o.first_low, SETUP); end
    checks++; if (o.wrong_low !== 0) begin errors++; $display("[TB] FAIL wr_ior_low: got %0d expected 0", o.wrong_low); end
    checks++; if (o.aen_cnt !== 0) begin errors++; $display("[TB] FAIL wr_aen: got %0d expected 0", o.aen_cnt); end
    checks++; if (o.oe_cnt !== e.window) begin errors++; $display("[TB] FAIL wr_data_oe: got %0d expected %0d", o.oe_cnt, e.window); end
    checks++; if (o.addr !== 16'h0220 || o.dout !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_addr_data: got %h/%h expected 0220/beef", o.addr, o.dout); end
    checks++; if (o.timeout !== 1'b0 || o.pulse !== 1) begin errors++; $display("[TB] FAIL wr_rsp: got timeout=%b pulses=%0d expected 0/1", o.timeout, o.pulse); end
  endtask

  task automatic test_read_wait;
    obs_t o; exp_t e;
    e = model(0, 0, 0, 0, 16'h0388, 16'h0, 16'h00A5, 3, 10);
    applyStimulus(0, 0, 0, 0, 16'h0388, 16'h0, 16'h00A5, 3, 10, o);
    checks++; if (o.strobe_low !== e.strobe_low) begin errors++; $display("[TB] FAIL rdw_ior_low: got %0d expected %0d", o.strobe_low, e.strobe_low); end
    checks++; if (o.latency !== e.latency) begin errors++; $display("[TB] FAIL rdw_latency: got %0d expected %0d", o.latency, e.latency); end
    checks++; if (o.rdata !== 16'h00A5 || o.timeout !== 1'b0) begin errors++; $display("[TB] FAIL rdw_rsp: got %h/%b expected 00a5/0", o.rdata, o.timeout); end
    checks++; if (o.wrong_low !== 0 || o.oe_cnt !== 0) begin errors++; $display("[TB] FAIL rdw_iow_oe: got %0d/%0d expected 0/0", o.wrong_low, o.oe_cnt); end
  endtask

  task automatic test_timeout;
    obs_t o;
    applyStimulus(0, 0, 0, 0, 16'h0300, 16'h0, 16'h1234, 1, 500, o);
    checks++; if (o.strobe_low !== STROBE + TMO) begin errors++; $display("[TB] FAIL tmo_ior_low: got %0d expected %0d", o.strobe_low, STROBE + TMO); end
    checks++; if (o.rdata !== 16'hFFFF || o.timeout !== 1'b1) begin errors++; $display("[TB] FAIL tmo_rsp: got %h/%b expected ffff/1", o.rdata, o.timeout); end
    checks++; if (o.latency !== SETUP + STROBE + TMO + HOLD + 1) begin errors++; $display("[TB] FAIL tmo_latency: got %0d expected %0d", o.latency, SETUP + STROBE + TMO + HOLD + 1); end
  endtask

  task automatic test_dma;
    obs_t o; exp_t e;
    @(negedge clk);
    drq = 4'b0100;
    @(posedge clk); #1;
    checks++; if (drq_sync !== 4'b0000) begin errors++; $display("[TB] FAIL drq_sync_1: got %b expected 0000", drq_sync); end
    @(posedge clk); #1;
    checks++; if (drq_sync !== 4'b0100) begin errors++; $display("[TB] FAIL drq_sync_2: got %b expected 0100", drq_sync); end
    e = model(1, 1, 2, 0, 16'h0ABC, 16'h5A5A, 16'h0, 1, 0);
    applyStimulus(1, 1, 2, 0, 16'h0ABC, 16'h5A5A, 16'h0, 1, 0, o);
    drq = 4'b0000;
    checks++; if (o.dack !== 4'b1011) begin errors++; $display("[TB] FAIL dma_dack: got %b expected 1011", o.dack); end
    checks++; if (o.aen_cnt !== e.window || o.dack_cnt !== e.window) begin errors++; $display("[TB] FAIL dma_window: got aen=%0d dack=%0d expected %0d", o.aen_cnt, o.dack_cnt, e.window); end
    checks++; if (o.addr !== 16'h0000) begin errors++; $display("[TB] FAIL dma_addr: got %h expected 0000", o.addr); end
    checks++; if (o.strobe_low !== 4 || o.latency !== 7) begin errors++; $display("[TB] FAIL dma_timing: got %0d/%0d expected 4/7", o.strobe_low, o.latency); end
  endtask

  task automatic test_byte;
    obs_t o;
    applyStimulus(0, 0, 0, 1, 16'h0060, 16'h0, 16'h12A5, 1, 0, o);
    checks++; if (o.rdata !== 16'h00A5) begin errors++; $display("[TB] FAIL byte_read: got %h expected 00a5", o.rdata); end
    applyStimulus(1, 0, 0, 1, 16'h0061, 16'h34CD, 16'h0, 1, 0, o);
    checks++; if (o.dout !== 16'h00CD) begin errors++; $display("[TB] FAIL byte_write: got %h expected 00cd", o.dout); end
  endtask

  task automatic test_random;
    obs_t o; exp_t e;
    logic wr, dma, byt; logic [1:0] ch; logic [15:0] addr, wd, din;
    int ls, ll;
    for (int n = 0; n < 16; n++) begin
      wr = 1'($urandom); dma = 1'($urandom); byt = 1'($urandom); ch = 2'($urandom);
      addr = 16'($urandom); wd = 16'($urandom); din = 16'($urandom);
      ls = $urandom_range(1, 8); ll = $urandom_range(0, 12);
      e = model(wr, dma, ch, byt, addr, wd, din, ls, ll);
      applyStimulus(wr, dma, ch, byt, addr, wd, din, ls, ll, o);
      checks++; if (o.latency !== e.latency) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", n, o.latency, e.latency); end
      checks++; if (o.strobe_low !== e.strobe_low || o.wrong_low !== 0) begin errors++; $display("[TB] FAIL rand%0d_strobe: got %0d/%0d expected %0d/0", n, o.strobe_low, o.wrong_low, e.strobe_low); end
      checks++; if (o.addr !== e.addr || o.dack !== e.dack) begin errors++; $display("[TB] FAIL rand%0d_addr_dack: got %h/%b expected %h/%b", n, o.addr, o.dack, e.addr, e.dack); end
      checks++; if (o.aen_cnt !== (dma ? e.window : 0) || o.oe_cnt !== (wr ? e.window : 0)) begin errors++; $display("[TB] FAIL rand%0d_aen_oe: got %0d/%0d expected %0d/%0d", n, o.aen_cnt, o.oe_cnt, dma ? e.window : 0, wr ? e.window : 0); end
      checks++; if (o.timeout !== e.timeout || o.pulse !== 1) begin errors++; $display("[TB] FAIL rand%0d_rsp: got %b/%0d expected %b/1", n, o.timeout, o.pulse, e.timeout); end
      if (wr) begin
        checks++; if (o.dout !== e.dout) begin errors++; $display("[TB] FAIL rand%0d_dout: got %h expected %h", n, o.dout, e.dout); end
      end else begin
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL rand%0d_rdata: got %h expected %h", n, o.rdata, e.rdata); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int pulses, gap, min_gap, k;
    bit prev_aen, in_gap;
    pulses = 0; gap = 0; min_gap = 1000; k = 0; prev_aen = 0; in_gap = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_dma = 1'b1; req_chan = 2'd0; req_byte = 1'b0;
    req_addr = 16'h0100; req_wdata = 16'hC3C3; iochrdy = 1'b1;
    while (pulses < 2 && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (rsp_valid) begin
        pulses++;
        if (pulses == 2) req_valid = 1'b0;
      end
      if (aen) begin
        if (in_gap && gap < min_gap) min_gap = gap;
        in_gap = 0;
      end else begin
        if (prev_aen) begin in_gap = 1; gap = 0; end
        if (in_gap) gap++;
      end
      prev_aen = aen;
    end
    req_valid = 1'b0;
    checks++; if (pulses !== 2) begin errors++; $display("[TB] FAIL b2b_responses: got %0d expected 2", pulses); end
    checks++; if (min_gap < 1 || min_gap == 1000) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0d expected >=1", min_gap); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_strobe;
    obs_t o;
    int guard;
    bit saw_rsp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_dma = 1'b1; req_chan = 2'd1; req_byte = 1'b0;
    req_addr = 16'h0300; data_in = 16'h7777; iochrdy = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (ior_n && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (guard >= 20) begin errors++; $display("[TB] FAIL rst_reach_strobe: got timeout expected ior_n low"); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({ior_n, iow_n} !== 2'b11) begin errors++; $display("[TB] FAIL rst_strobes: got %b expected 11", {ior_n, iow_n}); end
    checks++; if (dack_n !== 4'hF || aen !== 1'b0) begin errors++; $display("[TB] FAIL rst_dack_aen: got %b/%b expected 1111/0", dack_n, aen); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_rsp = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1;
    end
    checks++; if (saw_rsp !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_rsp: got rsp_valid expected none"); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_ready: got %b expected 1", req_ready); end
    applyStimulus(0, 0, 0, 0, 16'h0388, 16'h0, 16'h4321, 1, 0, o);
    checks++; if (o.latency !== 7 || o.rdata !== 16'h4321) begin errors++; $display("[TB] FAIL rst_next_read: got %0d/%h expected 7/4321", o.latency, o.rdata); end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_dma = 1'b0; req_chan = 2'd0;
    req_byte = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; data_in = 16'h0;
    iochrdy = 1'b1; drq = 4'h0;
    test_reset;
    test_write_basic;
    test_read_wait;
    test_timeout;
    test_dma;
    test_byte;
    test_random;
    test_back_to_back;
    test_reset_mid_strobe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
